// File: rtl/postoffice_send_queue_if.sv
// Bundle of the issue-side, commit-safety and network-side signals of the post office send queue.
// Optional flush input present only when XCTCMSG_SEND_FLUSH_EN is defined.
interface postoffice_send_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int DEST_W = 8,
    parameter int ID_W   = 8
);
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [DEST_W-1:0]          in_dest_i;
    logic [DATA_W-1:0]          in_data_i;
    logic [ID_W-1:0]            in_id_i;
    logic                       postoffice_csu_req_valid_o;
    logic [ID_W-1:0]            postoffice_csu_req_id_o;
    logic                       csu_postoffice_grant_i;
    logic                       net_valid_o;
    logic                       net_ready_i;
    logic [DEST_W-1:0]          net_dest_o;
    logic [DATA_W-1:0]          net_data_o;
    logic [$clog2(DEPTH):0]     count_o;
`ifdef XCTCMSG_SEND_FLUSH_EN
    logic                       flush_i;
`endif

    modport slave (
        input  in_valid_i, in_dest_i, in_data_i, in_id_i,
        output in_ready_o,
        output postoffice_csu_req_valid_o, postoffice_csu_req_id_o,
        input  csu_postoffice_grant_i,
        output net_valid_o, net_dest_o, net_data_o,
        input  net_ready_i,
        output count_o
`ifdef XCTCMSG_SEND_FLUSH_EN
        , input flush_i
`endif
    );

    modport master (
        output in_valid_i, in_dest_i, in_data_i, in_id_i,
        input  in_ready_o,
        input  postoffice_csu_req_valid_o, postoffice_csu_req_id_o,
        output csu_postoffice_grant_i,
        input  net_valid_o, net_dest_o, net_data_o,
        output net_ready_i,
        input  count_o
`ifdef XCTCMSG_SEND_FLUSH_EN
        , output flush_i
`endif
    );
endinterface

// File: rtl/postoffice_send_queue.sv
// Post office send queue: holds sends until the commit-safety unit grants the head, then hands them to the NoC.
// Optional feature: XCTCMSG_SEND_FLUSH_EN adds flush_i, which drops all uncommitted queue entries.
module postoffice_send_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int DEST_W = 8,
    parameter int ID_W   = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    postoffice_send_queue_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [DEST_W-1:0] r_dest_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [ID_W-1:0]   r_id_mem   [DEPTH];

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [0:0]        r_out_state;
    logic [DEST_W-1:0] r_out_dest;
    logic [DATA_W-1:0] r_out_data;

    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic              w_in_ready;
    logic              w_out_free;
    logic              w_req_valid;
    logic              w_push;
    logic              w_pop;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;

`ifdef XCTCMSG_SEND_FLUSH_EN
    assign w_flush = bus.flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign w_wr_idx    = r_wr_ptr[AW-1:0];
    assign w_rd_idx    = r_rd_ptr[AW-1:0];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    // No bypass: a full queue refuses input even in a cycle where the head pops.
    assign w_in_ready  = !w_full && !w_flush;
    assign w_out_free  = (r_out_state == S_EMPTY) || bus.net_ready_i;
    assign w_req_valid = !w_empty && w_out_free && !w_flush;
    assign w_push      = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_req_valid && bus.csu_postoffice_grant_i;

    assign bus.in_ready_o                 = w_in_ready;
    assign bus.postoffice_csu_req_valid_o = w_req_valid;
    assign bus.postoffice_csu_req_id_o    = w_empty ? {ID_W{1'b0}} : r_id_mem[w_rd_idx];
    assign bus.net_valid_o                = (r_out_state == S_HOLD);
    assign bus.net_dest_o                 = r_out_dest;
    assign bus.net_data_o                 = r_out_data;
    assign bus.count_o                    = r_count;

    // Queue storage: written at the tail on every accepted push.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dest_mem[i] <= '0;
                r_data_mem[i] <= '0;
                r_id_mem[i]   <= '0;
            end
        end else if (w_push) begin
            r_dest_mem[w_wr_idx] <= bus.in_dest_i;
            r_data_mem[w_wr_idx] <= bus.in_data_i;
            r_id_mem[w_wr_idx]   <= bus.in_id_i;
        end
    end

    // Pointers and occupancy; a flush discards everything between head and tail.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register FSM; a pop while HOLD implies net_ready, giving back-to-back transfers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_out_state <= S_EMPTY;
            r_out_dest  <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_out_state)
                S_EMPTY: begin
                    if (w_pop) begin
                        r_out_state <= S_HOLD;
                        r_out_dest  <= r_dest_mem[w_rd_idx];
                        r_out_data  <= r_data_mem[w_rd_idx];
                    end
                end
                S_HOLD: begin
                    if (w_pop) begin
                        r_out_state <= S_HOLD;
                        r_out_dest  <= r_dest_mem[w_rd_idx];
                        r_out_data  <= r_data_mem[w_rd_idx];
                    end else if (bus.net_ready_i) begin
                        r_out_state <= S_EMPTY;
                    end
                end
                default: r_out_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_postoffice_send_queue.sv
// Directed self-checking bench for postoffice_send_queue (DEPTH=4); flush scenario built with XCTCMSG_SEND_FLUSH_EN.
module tb_postoffice_send_queue;
    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    postoffice_send_queue_if #(.DEPTH(4), .DATA_W(64), .DEST_W(8), .ID_W(8)) bus ();

    postoffice_send_queue #(.DEPTH(4), .DATA_W(64), .DEST_W(8), .ID_W(8)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_in(input logic [7:0] id, input logic [7:0] dest, input logic [63:0] data);
        bus.in_valid_i = 1'b1;
        bus.in_id_i    = id;
        bus.in_dest_i  = dest;
        bus.in_data_i  = data;
    endtask

    task automatic drain();
        bus.in_valid_i             = 1'b0;
        bus.csu_postoffice_grant_i = 1'b1;
        bus.net_ready_i            = 1'b1;
        for (int k = 0; k < 20 && (bus.count_o != 3'd0 || bus.net_valid_o); k++) step();
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL drain_count: got %0d want 0", bus.count_o); else n_pass++;
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL drain_net_valid: got %0b want 0", bus.net_valid_o); else n_pass++;
        bus.csu_postoffice_grant_i = 1'b0;
        bus.net_ready_i            = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL reset_net_valid: got %0b want 0", bus.net_valid_o); else n_pass++;
        n_total++; if (bus.net_dest_o !== 8'h00) $display("FAIL reset_net_dest: got %0h want 0", bus.net_dest_o); else n_pass++;
        n_total++; if (bus.net_data_o !== 64'h0) $display("FAIL reset_net_data: got %0h want 0", bus.net_data_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", bus.postoffice_csu_req_valid_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_id_o !== 8'h00) $display("FAIL reset_req_id: got %0h want 0", bus.postoffice_csu_req_id_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count_o); else n_pass++;
        n_total++; if (bus.in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready_o); else n_pass++;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.csu_postoffice_grant_i = 1'b1;
        bus.net_ready_i            = 1'b1;
        push_in(8'd5, 8'd3, 64'hAB);
        step();
        bus.in_valid_i = 1'b0;
        #1;
        n_total++; if (bus.postoffice_csu_req_valid_o !== 1'b1) $display("FAIL single_req_valid: got %0b want 1", bus.postoffice_csu_req_valid_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_id_o !== 8'd5) $display("FAIL single_req_id: got %0d want 5", bus.postoffice_csu_req_id_o); else n_pass++;
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL single_net_valid_early: got %0b want 0", bus.net_valid_o); else n_pass++;
        step();
        n_total++; if (bus.net_valid_o !== 1'b1) $display("FAIL single_net_valid: got %0b want 1", bus.net_valid_o); else n_pass++;
        n_total++; if (bus.net_dest_o !== 8'd3) $display("FAIL single_net_dest: got %0d want 3", bus.net_dest_o); else n_pass++;
        n_total++; if (bus.net_data_o !== 64'hAB) $display("FAIL single_net_data: got %0h want ab", bus.net_data_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL single_count: got %0d want 0", bus.count_o); else n_pass++;
        step();
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL single_net_done: got %0b want 0", bus.net_valid_o); else n_pass++;
        bus.csu_postoffice_grant_i = 1'b0;
        bus.net_ready_i            = 1'b0;
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            push_in(8'(10 + k), 8'd1, 64'(k));
            step();
        end
        bus.in_valid_i = 1'b0;
        #1;
        n_total++; if (bus.count_o !== 3'd4) $display("FAIL full_count: got %0d want 4", bus.count_o); else n_pass++;
        n_total++; if (bus.in_ready_o !== 1'b0) $display("FAIL full_in_ready: got %0b want 0", bus.in_ready_o); else n_pass++;
        push_in(8'd14, 8'd1, 64'h4);
        step();
        bus.in_valid_i = 1'b0;
        #1;
        n_total++; if (bus.count_o !== 3'd4) $display("FAIL full_fifth_count: got %0d want 4", bus.count_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_id_o !== 8'd10) $display("FAIL full_req_id: got %0d want 10", bus.postoffice_csu_req_id_o); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            push_in(8'(20 + k), 8'(k), 64'h100 + 64'(k));
            step();
        end
        push_in(8'd99, 8'd9, 64'h999);
        bus.csu_postoffice_grant_i = 1'b1;
        #1;
        n_total++; if (bus.in_ready_o !== 1'b0) $display("FAIL b2b_no_bypass: got %0b want 0", bus.in_ready_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_valid_o !== 1'b1) $display("FAIL b2b_req_valid: got %0b want 1", bus.postoffice_csu_req_valid_o); else n_pass++;
        step();
        bus.in_valid_i             = 1'b0;
        bus.csu_postoffice_grant_i = 1'b0;
        #1;
        n_total++; if (bus.net_data_o !== 64'h100) $display("FAIL b2b_hold_data: got %0h want 100", bus.net_data_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd3) $display("FAIL b2b_hold_count: got %0d want 3", bus.count_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_valid_o !== 1'b0) $display("FAIL b2b_req_drop: got %0b want 0", bus.postoffice_csu_req_valid_o); else n_pass++;
        bus.csu_postoffice_grant_i = 1'b1;
        step();
        n_total++; if (bus.net_data_o !== 64'h100) $display("FAIL b2b_stable_data: got %0h want 100", bus.net_data_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd3) $display("FAIL b2b_grant_ignored: got %0d want 3", bus.count_o); else n_pass++;
        bus.net_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            n_total++; if (bus.net_valid_o !== 1'b1 || bus.net_data_o !== 64'h100 + 64'(k))
                $display("FAIL b2b_drain_%0d: got valid=%0b data=%0h want valid=1 data=%0h", k, bus.net_valid_o, bus.net_data_o, 64'h100 + 64'(k));
            else n_pass++;
        end
        bus.csu_postoffice_grant_i = 1'b0;
        step();
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL b2b_final_empty: got %0b want 0", bus.net_valid_o); else n_pass++;
        bus.net_ready_i = 1'b0;
    endtask

    task automatic test_ordering();
        bus.net_ready_i = 1'b1;
        push_in(8'd7, 8'd7, 64'h7);
        step();
        push_in(8'd9, 8'd9, 64'h9);
        step();
        bus.in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        n_total++; if (bus.count_o !== 3'd2 || bus.net_valid_o !== 1'b0)
            $display("FAIL order_no_grant: got count=%0d net_valid=%0b want count=2 net_valid=0", bus.count_o, bus.net_valid_o);
        else n_pass++;
        n_total++; if (bus.postoffice_csu_req_id_o !== 8'd7) $display("FAIL order_head_id: got %0d want 7", bus.postoffice_csu_req_id_o); else n_pass++;
        bus.csu_postoffice_grant_i = 1'b1;
        step();
        n_total++; if (bus.net_data_o !== 64'h7 || bus.net_valid_o !== 1'b1) $display("FAIL order_first: got %0h want 7", bus.net_data_o); else n_pass++;
        n_total++; if (bus.postoffice_csu_req_id_o !== 8'd9) $display("FAIL order_next_id: got %0d want 9", bus.postoffice_csu_req_id_o); else n_pass++;
        step();
        n_total++; if (bus.net_data_o !== 64'h9 || bus.net_valid_o !== 1'b1) $display("FAIL order_second: got %0h want 9", bus.net_data_o); else n_pass++;
        bus.csu_postoffice_grant_i = 1'b0;
        step();
        n_total++; if (bus.net_valid_o !== 1'b0) $display("FAIL order_done: got %0b want 0", bus.net_valid_o); else n_pass++;
        bus.net_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        bus.csu_postoffice_grant_i = 1'b1;
        bus.net_ready_i            = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_in(8'(30 + i), 8'(i), 64'h200 + 64'(i));
            step();
            n_total++; if (bus.count_o !== 3'd1 || bus.in_ready_o !== 1'b1)
                $display("FAIL wrap_flags_%0d: got count=%0d in_ready=%0b want count=1 in_ready=1", i, bus.count_o, bus.in_ready_o);
            else n_pass++;
            if (i > 0) begin
                n_total++; if (bus.net_valid_o !== 1'b1 || bus.net_data_o !== 64'h200 + 64'(i - 1))
                    $display("FAIL wrap_data_%0d: got %0h want %0h", i, bus.net_data_o, 64'h200 + 64'(i - 1));
                else n_pass++;
            end
        end
        drain();
    endtask

`ifdef XCTCMSG_SEND_FLUSH_EN
    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            push_in(8'(40 + k), 8'(k), 64'h400 + 64'(k));
            step();
        end
        bus.in_valid_i             = 1'b0;
        bus.csu_postoffice_grant_i = 1'b1;
        step();
        bus.csu_postoffice_grant_i = 1'b0;
        #1;
        n_total++; if (bus.count_o !== 3'd3 || bus.net_data_o !== 64'h400)
            $display("FAIL flush_setup: got count=%0d data=%0h want count=3 data=400", bus.count_o, bus.net_data_o);
        else n_pass++;
        bus.flush_i                = 1'b1;
        bus.csu_postoffice_grant_i = 1'b1;
        push_in(8'd50, 8'd5, 64'h500);
        #1;
        n_total++; if (bus.postoffice_csu_req_valid_o !== 1'b0) $display("FAIL flush_req_valid: got %0b want 0", bus.postoffice_csu_req_valid_o); else n_pass++;
        n_total++; if (bus.in_ready_o !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready_o); else n_pass++;
        step();
        bus.flush_i                = 1'b0;
        bus.in_valid_i             = 1'b0;
        bus.csu_postoffice_grant_i = 1'b0;
        #1;
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL flush_count: got %0d want 0", bus.count_o); else n_pass++;
        n_total++; if (bus.net_valid_o !== 1'b1 || bus.net_data_o !== 64'h400)
            $display("FAIL flush_out_kept: got valid=%0b data=%0h want valid=1 data=400", bus.net_valid_o, bus.net_data_o);
        else n_pass++;
        bus.net_ready_i = 1'b1;
        step();
        n_total++; if (bus.net_valid_o !== 1'b0 || bus.postoffice_csu_req_valid_o !== 1'b0)
            $display("FAIL flush_after: got net_valid=%0b req_valid=%0b want 0 0", bus.net_valid_o, bus.postoffice_csu_req_valid_o);
        else n_pass++;
        bus.net_ready_i = 1'b0;
    endtask
`endif

    initial begin
        n_pass                     = 0;
        n_total                    = 0;
        rstn                       = 1'b0;
        bus.in_valid_i             = 1'b0;
        bus.in_dest_i              = 8'h00;
        bus.in_data_i              = 64'h0;
        bus.in_id_i                = 8'h00;
        bus.csu_postoffice_grant_i = 1'b0;
        bus.net_ready_i            = 1'b0;
`ifdef XCTCMSG_SEND_FLUSH_EN
        bus.flush_i                = 1'b0;
`endif
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_ordering();
        test_wrap();
`ifdef XCTCMSG_SEND_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
